// File: rtl/systolic_sequencer.sv
// Sequencer for one DIMxDIM multiply on an output-stationary systolic array:
// latches operands, clears the array, streams skewed edges, drains, captures C.
module systolic_sequencer #(
    parameter int WIDTH = 32,
    parameter int DIM   = 4,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_mat    [DIM][DIM],
    input  logic [WIDTH-1:0] b_mat    [DIM][DIM],
    output logic             busy,
    output logic             done,
    output logic             arr_clr,
    output logic [WIDTH-1:0] a_feed   [DIM],
    output logic [WIDTH-1:0] b_feed   [DIM],
    input  logic [WIDTH-1:0] c_array  [DIM][DIM],
    output logic [WIDTH-1:0] c_result [DIM][DIM]
);
    // state   | meaning
    // S_IDLE  | waiting for start; operands latched on accept
    // S_CLEAR | one cycle of array clear
    // S_FEED  | skewed A rows / B columns streamed, cnt = t
    // S_DRAIN | wavefront settling, c_array captured on last cycle
    // S_DONE  | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    localparam int FEED_MAX  = 2*DIM - 2;
    localparam int DRAIN_MAX = DIM - 2 + LAT;
    localparam int CNT_MAX   = (FEED_MAX > DRAIN_MAX) ? FEED_MAX : DRAIN_MAX;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_MAX);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0] a_lat [DIM][DIM];
    logic [WIDTH-1:0] b_lat [DIM][DIM];
    logic [WIDTH-1:0] a_feed_nxt [DIM];
    logic [WIDTH-1:0] b_feed_nxt [DIM];
    logic            accept;

    assign accept = (state == S_IDLE) && start && !abort;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (cnt == FEED_LAST) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    // Feeds are registered, so they are computed from the upcoming state/count.
    always_comb begin
        for (int k = 0; k < DIM; k++) begin
            a_feed_nxt[k] = '0;
            b_feed_nxt[k] = '0;
            if (state_nxt == S_FEED) begin
                for (int j = 0; j < DIM; j++) begin
                    if (int'(cnt_nxt) == k + j) begin
                        a_feed_nxt[k] = a_lat[k][j];
                        b_feed_nxt[k] = b_lat[j][k];
                    end
                end
            end
        end
    end

    // Clear follows reset and abort within the same cycle so partial sums never survive.
    always_comb begin
        arr_clr = !rst || (state == S_CLEAR) || (abort && state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_feed   <= '{default: '0};
            b_feed   <= '{default: '0};
            c_result <= '{default: '0};
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= (state_nxt != S_IDLE);
            done   <= (state_nxt == S_DONE);
            a_feed <= a_feed_nxt;
            b_feed <= b_feed_nxt;
            if (state == S_DRAIN && cnt == DRAIN_LAST && !abort)
                c_result <= c_array;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat <= a_mat;
            b_lat <= b_mat;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural output-stationary array model.
module tb_systolic_sequencer;
    localparam int WIDTH = 8;
    localparam int DIM   = 4;
    localparam int LAT   = 1;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [WIDTH-1:0] a_mat [DIM][DIM];
    logic [WIDTH-1:0] b_mat [DIM][DIM];
    logic [WIDTH-1:0] a_feed [DIM];
    logic [WIDTH-1:0] b_feed [DIM];
    logic [WIDTH-1:0] c_array [DIM][DIM];
    logic [WIDTH-1:0] c_result [DIM][DIM];
    logic busy, done, arr_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_zero [DIM][DIM];
    logic [WIDTH-1:0] m_i    [DIM][DIM];
    logic [WIDTH-1:0] m_b    [DIM][DIM];
    logic [WIDTH-1:0] m_one  [DIM][DIM];
    logic [WIDTH-1:0] m_ff   [DIM][DIM];
    logic [WIDTH-1:0] m_d2   [DIM][DIM];
    logic [WIDTH-1:0] m_2b   [DIM][DIM];
    logic [WIDTH-1:0] m_rs   [DIM][DIM];

    always #5 clk = ~clk;

    systolic_sequencer #(.WIDTH(WIDTH), .DIM(DIM), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .busy     (busy),
        .done     (done),
        .arr_clr  (arr_clr),
        .a_feed   (a_feed),
        .b_feed   (b_feed),
        .c_array  (c_array),
        .c_result (c_result)
    );

    // Array model: A flows right, B flows down, each node accumulates locally.
    logic [WIDTH-1:0] a_in [DIM][DIM];
    logic [WIDTH-1:0] b_in [DIM][DIM];
    logic [WIDTH-1:0] ar   [DIM][DIM];
    logic [WIDTH-1:0] br   [DIM][DIM];
    logic [WIDTH-1:0] acc  [DIM][DIM];

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_in[i][0] = a_feed[i];
            b_in[0][i] = b_feed[i];
            for (int j = 1; j < DIM; j++) begin
                a_in[i][j] = ar[i][j-1];
                b_in[j][i] = br[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        if (arr_clr) begin
            acc <= '{default: '0};
            ar  <= '{default: '0};
            br  <= '{default: '0};
        end else begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    acc[i][j] <= acc[i][j] + a_in[i][j] * b_in[i][j];
            ar <= a_in;
            br <= b_in;
        end
    end

    assign c_array = acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        a_mat = m_zero; b_mat = m_zero;
        tick();
        tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (arr_clr !== 1'b1) begin n_err++; $display("FAIL reset_arr_clr got %b exp 1", arr_clr); end
        for (int k = 0; k < DIM; k++) begin
            n_cmp++; if (a_feed[k] !== '0 || b_feed[k] !== '0) begin
                n_err++; $display("FAIL reset_feed k=%0d got a=%0h b=%0h exp 0", k, a_feed[k], b_feed[k]);
            end
        end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                n_cmp++; if (c_result[i][j] !== '0) begin
                    n_err++; $display("FAIL reset_c_result [%0d][%0d] got %0h exp 0", i, j, c_result[i][j]);
                end
            end
        rst = 1'b1;
        #1;
        n_cmp++; if (arr_clr !== 1'b0) begin n_err++; $display("FAIL reset_release_arr_clr got %b exp 0", arr_clr); end
        tick();
    endtask

    task automatic test_all_ones();
        a_mat = m_one; b_mat = m_one;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0);
            #1;
            n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL ones_done c=%0d got %b exp %b", c, done, c == 13); end
            n_cmp++; if ((a_feed[3] != '0) !== (c >= 5 && c <= 8)) begin
                n_err++; $display("FAIL ones_a_feed3 c=%0d got %0h", c, a_feed[3]);
            end
            n_cmp++; if ((b_feed[0] != '0) !== (c >= 2 && c <= 5)) begin
                n_err++; $display("FAIL ones_b_feed0 c=%0d got %0h", c, b_feed[0]);
            end
            if (c == 13)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== 8'd4) begin
                            n_err++; $display("FAIL ones_c [%0d][%0d] got %0h exp 4", i, j, c_result[i][j]);
                        end
                    end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_identity();
        logic [WIDTH-1:0] ea, eb;
        int t;
        a_mat = m_i; b_mat = m_b;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0);
            #1;
            n_cmp++; if (busy !== (c >= 1 && c <= 13)) begin n_err++; $display("FAIL ident_busy c=%0d got %b", c, busy); end
            n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL ident_done c=%0d got %b", c, done); end
            n_cmp++; if (arr_clr !== (c == 1)) begin n_err++; $display("FAIL ident_arr_clr c=%0d got %b", c, arr_clr); end
            t = c - 2;
            for (int k = 0; k < DIM; k++) begin
                ea = '0; eb = '0;
                if (c >= 2 && c <= 8 && t - k >= 0 && t - k < DIM) begin
                    ea = m_i[k][t-k];
                    eb = m_b[t-k][k];
                end
                n_cmp++; if (a_feed[k] !== ea || b_feed[k] !== eb) begin
                    n_err++; $display("FAIL ident_feed c=%0d k=%0d got a=%0h b=%0h exp a=%0h b=%0h", c, k, a_feed[k], b_feed[k], ea, eb);
                end
            end
            if (c == 13)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== m_b[i][j]) begin
                            n_err++; $display("FAIL ident_c [%0d][%0d] got %0h exp %0h", i, j, c_result[i][j], m_b[i][j]);
                        end
                    end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_overflow();
        a_mat = m_ff; b_mat = m_ff;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0);
            #1;
            n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL ovf_done c=%0d got %b", c, done); end
            if (c == 13)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== 8'h04) begin
                            n_err++; $display("FAIL ovf_c [%0d][%0d] got %0h exp 04", i, j, c_result[i][j]);
                        end
                    end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_start_while_busy();
        a_mat = m_i; b_mat = m_b;
        for (int c = 0; c < 31; c++) begin
            start = (c == 0 || c == 5 || c == 13);
            if (c == 5 || c == 13) begin a_mat = m_one; b_mat = m_one; end
            #1;
            n_cmp++; if (busy !== (c >= 1 && c <= 13)) begin n_err++; $display("FAIL swb_busy c=%0d got %b", c, busy); end
            n_cmp++; if (done !== (c == 13)) begin n_err++; $display("FAIL swb_done c=%0d got %b", c, done); end
            if (c == 13 || c == 30)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== m_b[i][j]) begin
                            n_err++; $display("FAIL swb_c c=%0d [%0d][%0d] got %0h exp %0h", c, i, j, c_result[i][j], m_b[i][j]);
                        end
                    end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        a_mat = m_d2; b_mat = m_b;
        for (int c = 0; c < 24; c++) begin
            start = (c == 0 || c == 7 || c == 8);
            abort = (c == 6 || c == 7);
            if (c == 9) begin a_mat = m_one; b_mat = m_one; end
            #1;
            n_cmp++; if (busy !== ((c >= 1 && c <= 6) || (c >= 9 && c <= 21))) begin
                n_err++; $display("FAIL abort_busy c=%0d got %b", c, busy);
            end
            n_cmp++; if (done !== (c == 21)) begin n_err++; $display("FAIL abort_done c=%0d got %b", c, done); end
            n_cmp++; if (arr_clr !== (c == 1 || c == 6 || c == 9)) begin
                n_err++; $display("FAIL abort_arr_clr c=%0d got %b", c, arr_clr);
            end
            if (c == 7 || c == 20)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== m_b[i][j]) begin
                            n_err++; $display("FAIL abort_hold c=%0d [%0d][%0d] got %0h exp %0h", c, i, j, c_result[i][j], m_b[i][j]);
                        end
                    end
            if (c == 21)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        n_cmp++; if (c_result[i][j] !== m_2b[i][j]) begin
                            n_err++; $display("FAIL abort_rerun_c [%0d][%0d] got %0h exp %0h", i, j, c_result[i][j], m_2b[i][j]);
                        end
                    end
            tick();
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a_mat = m_i; b_mat = m_one;
        for (int c = 0; c < 29; c++) begin
            start = (c == 0 || c == 13);
            rst   = !(c == 10 || c == 11);
            if (c == 13) begin a_mat = m_one; b_mat = m_b; end
            #1;
            n_cmp++; if (busy !== ((c >= 1 && c <= 10) || (c >= 14 && c <= 26))) begin
                n_err++; $display("FAIL rstmid_busy c=%0d got %b", c, busy);
            end
            n_cmp++; if (done !== (c == 26)) begin n_err++; $display("FAIL rstmid_done c=%0d got %b", c, done); end
            n_cmp++; if (arr_clr !== (c == 1 || c == 10 || c == 11 || c == 14)) begin
                n_err++; $display("FAIL rstmid_arr_clr c=%0d got %b", c, arr_clr);
            end
            if (c == 11 || c == 12)
                for (int k = 0; k < DIM; k++) begin
                    n_cmp++; if (a_feed[k] !== '0 || b_feed[k] !== '0) begin
                        n_err++; $display("FAIL rstmid_feed c=%0d k=%0d got a=%0h b=%0h exp 0", c, k, a_feed[k], b_feed[k]);
                    end
                end
            if (c == 9 || c == 11 || c == 12 || c == 26)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        logic [WIDTH-1:0] ec;
                        ec = (c == 9) ? m_2b[i][j] : (c == 26) ? m_rs[i][j] : '0;
                        n_cmp++; if (c_result[i][j] !== ec) begin
                            n_err++; $display("FAIL rstmid_c c=%0d [%0d][%0d] got %0h exp %0h", c, i, j, c_result[i][j], ec);
                        end
                    end
            tick();
        end
        start = 1'b0; rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                m_zero[i][j] = '0;
                m_i[i][j]    = (i == j) ? 8'd1 : 8'd0;
                m_b[i][j]    = 8'(4*i + j + 1);
                m_one[i][j]  = 8'd1;
                m_ff[i][j]   = 8'hFF;
                m_d2[i][j]   = (i == j) ? 8'd2 : 8'd0;
                m_2b[i][j]   = 8'(2*(4*i + j + 1));
                m_rs[i][j]   = 8'(28 + 4*j);
            end
        test_reset();
        test_all_ones();
        test_identity();
        test_overflow();
        test_start_while_busy();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
